// File: rtl/uart_alarm_loader_pkg.sv
// Shared types and constants for the UART alarm loader and the clock/alarm blocks
// that consume its hour/minute/second values.
package uart_alarm_loader_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
    localparam logic [7:0] MAX_HOUR       = 8'd23;
    localparam logic [7:0] MAX_MIN        = 8'd59;
    localparam logic [7:0] MAX_SEC        = 8'd59;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_HOUR = 3'd1,
        P_MIN  = 3'd2,
        P_SEC  = 3'd3,
        P_CHK  = 3'd4
    } parse_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_e;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                       input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // A frame is usable only if the XOR checksum matches and every field is in range.
    function automatic logic frame_ok(input logic [7:0] hour, input logic [7:0] min,
                                      input logic [7:0] sec, input logic [7:0] chk);
        return (chk == (hour ^ min ^ sec)) && !hour[7] && !min[7] && !sec[7] &&
               (hour <= MAX_HOUR) && (min <= MAX_MIN) && (sec <= MAX_SEC);
    endfunction

endpackage

// File: rtl/uart_alarm_loader_rx.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling and stop-bit check.
module uart_rx_byte
    import uart_alarm_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    rx_state_e   st_q, st_d;
    logic [1:0]  sync_q, sync_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        rx_s;

    assign rx_s     = sync_q[1];
    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

    // Receiver state register; synchroniser resets to the idle-high line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= RX_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: a low line in idle is a start edge; it must still be low at half a bit
    always_comb begin
        st_d    = st_q;
        sync_d  = {sync_q[0], rx};
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s) begin
                    st_d = RX_START;
                end else begin
                    st_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    bit_d = 3'd0;
                    st_d  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    st_d = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    st_d    = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    st_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        st_d    = RX_IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        st_d   = RX_WAIT;
                    end
                end else begin
                    st_d = RX_STOP;
                end
            end
            RX_WAIT: begin
                cnt_d = 16'd0;
                st_d  = rx_s ? RX_IDLE : RX_WAIT;
            end
            default: begin
                cnt_d = 16'd0;
                st_d  = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_alarm_loader.sv
// Frame parser in front of the alarm: HEADER, hour, minute, second, XOR checksum.
// Time outputs and uart_sign only ever change on a fully validated frame.
module uart_alarm_loader
    import uart_alarm_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD         = 9600,
    parameter logic [7:0]  HEADER       = HEADER_DEFAULT,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       sign_clr,
    output logic [6:0] Big_uart,
    output logic [6:0] Middle_uart,
    output logic [6:0] Less_uart,
    output logic [6:0] uart_sign,
    output logic       frame_err
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ferr;

    parse_state_e state_q, state_d;
    logic [7:0]   hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [31:0]  tmo_q, tmo_d;
    logic [6:0]   big_q, big_d, mid_q, mid_d, less_q, less_d;
    logic         sign_q, sign_d;
    logic         ferr_q, ferr_d;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign Big_uart    = big_q;
    assign Middle_uart = mid_q;
    assign Less_uart   = less_q;
    assign uart_sign   = {6'd0, sign_q};
    assign frame_err   = ferr_q;

    // Parser, shadow, timeout and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= P_IDLE;
            hour_q  <= 8'd0;
            min_q   <= 8'd0;
            sec_q   <= 8'd0;
            tmo_q   <= 32'd0;
            big_q   <= 7'd0;
            mid_q   <= 7'd0;
            less_q  <= 7'd0;
            sign_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tmo_q   <= tmo_d;
            big_q   <= big_d;
            mid_q   <= mid_d;
            less_q  <= less_d;
            sign_q  <= sign_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic; a frame accept sets uart_sign even when sign_clr is high
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tmo_d   = (rx_valid || (state_q == P_IDLE)) ? 32'd0 : tmo_q + 32'd1;
        big_d   = big_q;
        mid_d   = mid_q;
        less_d  = less_q;
        sign_d  = sign_clr ? 1'b0 : sign_q;
        ferr_d  = 1'b0;
        case (state_q)
            P_IDLE: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    state_d = P_HOUR;
                end else begin
                    state_d = P_IDLE;
                end
            end
            P_HOUR: begin
                if (rx_valid) begin
                    hour_d  = rx_data;
                    state_d = P_MIN;
                end else begin
                    state_d = P_HOUR;
                end
            end
            P_MIN: begin
                if (rx_valid) begin
                    min_d   = rx_data;
                    state_d = P_SEC;
                end else begin
                    state_d = P_MIN;
                end
            end
            P_SEC: begin
                if (rx_valid) begin
                    sec_d   = rx_data;
                    state_d = P_CHK;
                end else begin
                    state_d = P_SEC;
                end
            end
            P_CHK: begin
                if (rx_valid) begin
                    state_d = P_IDLE;
                    if (frame_ok(hour_q, min_q, sec_q, rx_data)) begin
                        big_d  = hour_q[6:0];
                        mid_d  = min_q[6:0];
                        less_d = sec_q[6:0];
                        sign_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    state_d = P_CHK;
                end
            end
            default: begin
                state_d = P_IDLE;
            end
        endcase
        // Mid-frame line errors and stalls abandon the frame
        if ((state_q != P_IDLE) && !rx_valid && (rx_ferr || (tmo_q == TMO_LAST))) begin
            ferr_d  = 1'b1;
            state_d = P_IDLE;
        end else begin
            ferr_d = ferr_d;
        end
    end

endmodule

// File: tb/tb_uart_alarm_loader.sv
// Directed bench for uart_alarm_loader at 10 clocks per bit.
module tb_uart_alarm_loader;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       sign_clr;
    logic [6:0] Big_uart;
    logic [6:0] Middle_uart;
    logic [6:0] Less_uart;
    logic [6:0] uart_sign;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int ferr_cnt = 0;
    logic [6:0] sign_at98;
    logic [6:0] sign_at99;
    logic [6:0] big_at98;
    logic [6:0] big_at99;

    uart_alarm_loader #(
        .CLK_FREQ     (1000000),
        .BAUD         (100000),
        .HEADER       (8'hAA),
        .TIMEOUT_BITS (40)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .sign_clr    (sign_clr),
        .Big_uart    (Big_uart),
        .Middle_uart (Middle_uart),
        .Less_uart   (Less_uart),
        .uart_sign   (uart_sign),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the stop bit. Snapshots the
    // outputs two and one cycles before the end; optional sign_clr pulse in between.
    task automatic send_byte(input logic [7:0] b, input logic clr);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (i == 9 && c == 7) begin
                    sign_at98 = uart_sign;
                    big_at98  = Big_uart;
                    if (clr) sign_clr = 1'b1;
                end
                if (i == 9 && c == 8) begin
                    sign_clr  = 1'b0;
                    sign_at99 = uart_sign;
                    big_at99  = Big_uart;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic [7:0] k, input logic clr);
        send_byte(8'hAA, 1'b0);
        send_byte(h, 1'b0);
        send_byte(m, 1'b0);
        send_byte(s, 1'b0);
        send_byte(k, clr);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        rx       = 1'b1;
        sign_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_big",  32'(Big_uart),    32'd0);
        check("rst_mid",  32'(Middle_uart), 32'd0);
        check("rst_less", 32'(Less_uart),   32'd0);
        check("rst_sign", 32'(uart_sign),   32'd0);
        check("rst_ferr", 32'(frame_err),   32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 12:30:45, checksum 0C^1E^2D = 3F
        send_frame(8'h0C, 8'h1E, 8'h2D, 8'h3F, 1'b0);
        check("f1_sign_before", 32'(sign_at98), 32'd0);
        check("f1_big_before",  32'(big_at98),  32'd0);
        check("f1_sign_after",  32'(sign_at99), 32'd1);
        check("f1_big_after",   32'(big_at99),  32'd12);
        check("f1_mid",  32'(Middle_uart), 32'd30);
        check("f1_less", 32'(Less_uart),   32'd45);
        check("f1_ferr", 32'(ferr_cnt),    32'd0);

        // Bad checksum
        send_frame(8'h0C, 8'h1E, 8'h2D, 8'h00, 1'b0);
        check("cks_ferr", 32'(ferr_cnt),    32'd1);
        check("cks_big",  32'(Big_uart),    32'd12);
        check("cks_less", 32'(Less_uart),   32'd45);
        check("cks_sign", 32'(uart_sign),   32'd1);

        // Hour 24 with a correct checksum
        send_frame(8'h18, 8'h00, 8'h00, 8'h18, 1'b0);
        check("h24_ferr", 32'(ferr_cnt), 32'd2);
        check("h24_big",  32'(Big_uart), 32'd12);
        check("h24_mid",  32'(Middle_uart), 32'd30);

        // Stall after the hour byte: nothing at 30 bit times, error by 50
        send_byte(8'hAA, 1'b0);
        send_byte(8'h05, 1'b0);
        repeat (300) @(negedge clk);
        check("tmo_early", 32'(ferr_cnt), 32'd2);
        repeat (200) @(negedge clk);
        check("tmo_fire",  32'(ferr_cnt), 32'd3);
        send_frame(8'h05, 8'h06, 8'h07, 8'h04, 1'b0);
        check("tmo_big",  32'(Big_uart),    32'd5);
        check("tmo_mid",  32'(Middle_uart), 32'd6);
        check("tmo_less", 32'(Less_uart),   32'd7);
        check("tmo_ferr", 32'(ferr_cnt),   32'd3);

        // Non-header bytes, then a one-clock glitch, then a good frame
        send_byte(8'h55, 1'b0);
        send_byte(8'h33, 1'b0);
        repeat (5) @(negedge clk);
        check("junk_ferr", 32'(ferr_cnt), 32'd3);
        check("junk_big",  32'(Big_uart), 32'd5);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 1'b0);
        check("gl_big",  32'(Big_uart),    32'd1);
        check("gl_mid",  32'(Middle_uart), 32'd2);
        check("gl_less", 32'(Less_uart),   32'd3);
        check("gl_ferr", 32'(ferr_cnt),    32'd3);

        // sign_clr in the cycle the accept lands: set wins
        send_frame(8'h0A, 8'h14, 8'h1E, 8'h00, 1'b1);
        check("clr_sign_before", 32'(sign_at98), 32'd1);
        check("clr_sign_after",  32'(sign_at99), 32'd1);
        check("clr_big",         32'(big_at99),  32'd10);
        sign_clr = 1'b1;
        @(negedge clk);
        sign_clr = 1'b0;
        @(negedge clk);
        check("lone_clr_sign", 32'(uart_sign), 32'd0);
        check("lone_clr_big",  32'(Big_uart),  32'd10);

        // Re-arm uart_sign, then reset in the middle of a header byte
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 1'b0);
        check("pre_rst_sign", 32'(uart_sign), 32'd1);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_big",  32'(Big_uart),    32'd0);
        check("mrst_mid",  32'(Middle_uart), 32'd0);
        check("mrst_less", 32'(Less_uart),   32'd0);
        check("mrst_sign", 32'(uart_sign),   32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_ferr", 32'(ferr_cnt),  32'd3);
        check("post_rst_sign", 32'(uart_sign), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
